// File: rtl/lane_frame_scheduler_pkg.sv
// Shared display constants, FSM state type and the tile
// bit indexing helper for the lane frame scheduler.
package lane_frame_scheduler_pkg;

  localparam int ROWS          = 120;
  localparam int LANE_W        = 8;
  localparam int LANES         = 3;
  localparam int PIX_PER_FRAME = LANES * ROWS * LANE_W;

  localparam logic [7:0] LANE_X0_DEF = 8'd50;
  localparam logic [7:0] LANE_X1_DEF = 8'd76;
  localparam logic [7:0] LANE_X2_DEF = 8'd102;
  localparam logic [2:0] FG_DEF      = 3'b100;
  localparam logic [2:0] BG_DEF      = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } state_t;

  function automatic logic [8:0] pix_idx(
    input logic [1:0] l,
    input logic [6:0] r
  );
    return 9'(l) * 9'(ROWS) + 9'(r);
  endfunction

endpackage

// File: rtl/lane_frame_scheduler_counter.sv
// Column-fastest pixel walker over lanes, rows and the
// eight columns of each lane.
module lane_pixel_counter
  import lane_frame_scheduler_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear,
  input  logic       advance,
  output logic [1:0] lane,
  output logic [6:0] row,
  output logic [2:0] col,
  output logic       last
);

  logic col_end;
  logic row_end;

  assign col_end = (col == 3'(LANE_W - 1));
  assign row_end = (row == 7'(ROWS - 1));
  assign last    = col_end && row_end &&
                   (lane == 2'(LANES - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lane <= '0;
      row  <= '0;
      col  <= '0;
    end else if (clear) begin
      lane <= '0;
      row  <= '0;
      col  <= '0;
    end else if (advance) begin
      col <= col + 3'd1;
      if (col_end) begin
        row <= row_end ? '0 : row + 7'd1;
        if (row_end)
          lane <= last ? '0 : lane + 2'd1;
      end
    end
  end

endmodule

// File: rtl/lane_frame_scheduler.sv
// Redraws three 8-pixel-wide tile lanes from a snapshot of
// lane_data, one pixel per clock, on each accepted tick.
module lane_frame_scheduler
  import lane_frame_scheduler_pkg::*;
#(
  parameter logic [7:0] LANE_X0 = LANE_X0_DEF,
  parameter logic [7:0] LANE_X1 = LANE_X1_DEF,
  parameter logic [7:0] LANE_X2 = LANE_X2_DEF,
  parameter logic [2:0] FG      = FG_DEF,
  parameter logic [2:0] BG      = BG_DEF
)
(
  input  logic         clock,
  input  logic         resetn,
  input  logic         frame_tick,
  input  logic         enable,
  input  logic [359:0] lane_data,
  output logic [7:0]   x,
  output logic [6:0]   y,
  output logic [2:0]   colour,
  output logic         plot,
  output logic         busy,
  output logic         frame_done,
  output logic         overrun
);

  state_t       state;
  logic [359:0] snap;
  logic         tail;
  logic         accept;
  logic         stepping;
  logic [1:0]   lane;
  logic [6:0]   row;
  logic [2:0]   col;
  logic         last;
  logic [7:0]   base;

  assign accept   = frame_tick && enable &&
                    (state != DRAW);
  assign stepping = (state == DRAW) && enable && !tail;
  assign busy     = (state == DRAW);

  lane_pixel_counter u_cnt (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (accept),
    .advance (stepping),
    .lane    (lane),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  always_comb begin
    base = LANE_X2;
    unique case (1'b1)
      (lane == 2'd0): base = LANE_X0;
      (lane == 2'd1): base = LANE_X1;
      default:        base = LANE_X2;
    endcase
  end

  // tail marks the one idle DRAW cycle after the terminal pixel
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      snap       <= '0;
      tail       <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      plot       <= 1'b0;
      frame_done <= 1'b0;
      if (frame_tick && state == DRAW)
        overrun <= 1'b1;
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            snap  <= lane_data;
            tail  <= 1'b0;
            state <= DRAW;
          end else begin
            state <= IDLE;
          end
        end
        DRAW: begin
          if (!enable) begin
            state <= IDLE;
          end else if (tail) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            plot   <= 1'b1;
            x      <= base + 8'(col);
            y      <= row;
            colour <= snap[pix_idx(lane, row)] ? FG : BG;
            tail   <= last;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_frame_scheduler.sv
// Scoreboard bench: each accepted tick queues the expected
// 2880 pixels, every plot pops and compares one.
module tb_lane_frame_scheduler;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         frame_tick = 1'b0;
  logic         enable = 1'b0;
  logic [359:0] lane_data = '0;
  logic [7:0]   x;
  logic [6:0]   y;
  logic [2:0]   colour;
  logic         plot;
  logic         busy;
  logic         frame_done;
  logic         overrun;

  int vectors = 0;
  int errors  = 0;
  int nplot, ndone, done_at, cyc;
  bit toggle = 1'b0;
  logic [17:0] q[$];

  lane_frame_scheduler dut (
    .clock      (clock),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .enable     (enable),
    .lane_data  (lane_data),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [359:0] s);
    int bx[3] = '{50, 76, 102};
    for (int l = 0; l < 3; l++)
      for (int r = 0; r < 120; r++)
        for (int c = 0; c < 8; c++)
          q.push_back({8'(bx[l] + c), 7'(r),
                       s[l*120+r] ? 3'b100 : 3'b000});
  endtask

  task automatic cycle();
    logic [17:0] e;
    @(posedge clock);
    #1;
    cyc++;
    if (frame_done) begin
      ndone++;
      done_at = cyc;
    end
    if (plot) begin
      nplot++;
      if (q.size() == 0) begin
        check("extra_plot", 1, 0);
      end else begin
        e = q.pop_front();
        check("pixel", 32'({x, y, colour}), 32'(e));
      end
    end
    if (toggle) lane_data = ~lane_data;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic start_frame();
    logic [359:0] s;
    s = lane_data;
    frame_tick = 1'b1;
    enable = 1'b1;
    cycle();
    frame_tick = 1'b0;
    push_frame(s);
    cyc = 0;
    nplot = 0;
    ndone = 0;
    done_at = -1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_x"}, 32'(x), 0);
    check({tag, "_y"}, 32'(y), 0);
    check({tag, "_col"}, 32'(colour), 0);
    check({tag, "_plot"}, 32'(plot), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(frame_done), 0);
    check({tag, "_ovr"}, 32'(overrun), 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    check_zero("rst");
    @(posedge clock);
    #1;
    resetn = 1'b1;
    q.delete();
  endtask

  task automatic full_frame_checks(input string tag);
    check({tag, "_plots"}, 32'(nplot), 2880);
    check({tag, "_ndone"}, 32'(ndone), 1);
    check({tag, "_done_at"}, 32'(done_at), 2881);
    check({tag, "_qempty"}, 32'(q.size()), 0);
  endtask

  initial begin
    #2;
    do_reset();

    // one frame, three lit tiles
    lane_data[0] = 1'b1;
    lane_data[125] = 1'b1;
    lane_data[359] = 1'b1;
    run(2);
    check("idle_plot", 32'(plot), 0);
    start_frame();
    check("busy_draw", 32'(busy), 1);
    check("ovr0", 32'(overrun), 0);
    run(2881);
    full_frame_checks("f1");
    check("f1_done_now", 32'(frame_done), 1);
    check("f1_busy_done", 32'(busy), 0);
    run(1);
    check("f1_done_clr", 32'(frame_done), 0);
    check("f1_busy_idle", 32'(busy), 0);

    // second tick mid-frame sets sticky overrun
    start_frame();
    run(99);
    frame_tick = 1'b1;
    lane_data = ~lane_data;
    run(1);
    frame_tick = 1'b0;
    run(2781);
    full_frame_checks("ovr");
    check("ovr_set", 32'(overrun), 1);
    run(3);
    check("ovr_sticky", 32'(overrun), 1);

    // enable dropped mid-frame
    start_frame();
    run(1499);
    enable = 1'b0;
    run(1);
    check("abort_plot", 32'(plot), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_plots", 32'(nplot), 1499);
    q.delete();
    enable = 1'b1;
    run(5);
    check("abort_noplot", 32'(nplot), 1499);
    check("abort_nodone", 32'(ndone), 0);
    start_frame();
    run(2881);
    full_frame_checks("redraw");
    run(1);

    // tick in the DONE cycle
    do_reset();
    for (int i = 0; i < 360; i++)
      lane_data[i] = 1'($urandom_range(0, 1));
    start_frame();
    run(2881);
    check("b2b_done", 32'(frame_done), 1);
    check("b2b_plots1", 32'(nplot), 2880);
    lane_data = ~lane_data;
    start_frame();
    check("b2b_busy", 32'(busy), 1);
    run(1);
    check("b2b_plot", 32'(plot), 1);
    check("b2b_x", 32'(x), 50);
    check("b2b_y", 32'(y), 0);
    run(2880);
    full_frame_checks("b2b");
    check("b2b_ovr", 32'(overrun), 0);
    run(1);

    // lane_data toggling during DRAW
    toggle = 1'b1;
    start_frame();
    run(2881);
    toggle = 1'b0;
    full_frame_checks("tog");
    run(1);

    // reset mid-frame
    start_frame();
    run(2000);
    check("rst_plots", 32'(nplot), 2000);
    do_reset();
    nplot = 0;
    ndone = 0;
    run(10);
    check("rst_noplot", 32'(nplot), 0);
    check("rst_nodone", 32'(ndone), 0);
    start_frame();
    run(1);
    check("rst_resume", 32'(plot), 1);
    check("rst_x", 32'(x), 50);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
